// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 keyboard receiver and make/break decoder
// Turns raw PS/2 pin activity into per-key held levels plus a one-cycle event strobe.
module ps2_key_decoder #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         PS2_CLK,
    input  logic         PS2_DATA,
    output logic [511:0] key_down,
    output logic [8:0]   last_change,
    output logic         key_valid,
    output logic         frame_err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_BITS, RX_CHECK} rx_state_t;
    typedef enum logic [1:0] {C_IDLE, C_EXT, C_BRK, C_EXT_BRK} code_state_t;

    logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic          r_clk_filt, r_clk_filt_d;
    logic [FW-1:0] r_filt_cnt;
    rx_state_t     r_rx_state;
    logic [3:0]    r_bit_cnt;
    logic [10:0]   r_shift;
    logic [TW-1:0] r_to_cnt;
    logic          r_frame_err;
    code_state_t   r_code_state;
    logic [511:0]  r_key_down;
    logic [8:0]    r_last_change;
    logic          r_key_valid;

    logic          w_fall;
    logic          w_frame_ok;
    logic [7:0]    w_byte;
    logic          w_ext;
    logic          w_brk;
    logic          w_ignored;
    logic [8:0]    w_code;

    assign w_fall     = r_clk_filt_d & ~r_clk_filt;
    assign w_frame_ok = (r_rx_state == RX_CHECK) && !r_shift[0] && r_shift[10] && (^r_shift[9:1]);
    assign w_byte     = r_shift[8:1];
    assign w_ext      = (r_code_state == C_EXT) || (r_code_state == C_EXT_BRK);
    assign w_brk      = (r_code_state == C_BRK) || (r_code_state == C_EXT_BRK);
    assign w_code     = {w_ext, w_byte};
    assign w_ignored  = (r_code_state == C_IDLE) &&
                        ((w_byte == 8'hAA) || (w_byte == 8'hFA) || (w_byte == 8'hFE) ||
                         (w_byte == 8'h00) || (w_byte == 8'hFF));

    assign key_down    = r_key_down;
    assign last_change = r_last_change;
    assign key_valid   = r_key_valid;
    assign frame_err   = r_frame_err;

    // Synchronizers idle high so a reset never manufactures a falling edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_clk_s1     <= 1'b1;
            r_clk_s2     <= 1'b1;
            r_dat_s1     <= 1'b1;
            r_dat_s2     <= 1'b1;
            r_clk_filt   <= 1'b1;
            r_clk_filt_d <= 1'b1;
            r_filt_cnt   <= '0;
        end else begin
            r_clk_s1     <= PS2_CLK;
            r_clk_s2     <= r_clk_s1;
            r_dat_s1     <= PS2_DATA;
            r_dat_s2     <= r_dat_s1;
            r_clk_filt_d <= r_clk_filt;
            if (r_clk_s2 == r_clk_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
                r_clk_filt <= r_clk_s2;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rx_state  <= RX_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_to_cnt    <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    r_to_cnt <= '0;
                    if (w_fall) begin
                        if (r_dat_s2) begin
                            r_frame_err <= 1'b1;
                        end else begin
                            r_shift    <= {r_dat_s2, r_shift[10:1]};
                            r_bit_cnt  <= 4'd1;
                            r_rx_state <= RX_BITS;
                        end
                    end
                end
                RX_BITS: begin
                    if (w_fall) begin
                        r_shift  <= {r_dat_s2, r_shift[10:1]};
                        r_to_cnt <= '0;
                        if (r_bit_cnt == 4'd10) begin
                            r_rx_state <= RX_CHECK;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end else if (r_to_cnt == TW'(TIMEOUT - 1)) begin
                        r_frame_err <= 1'b1;
                        r_rx_state  <= RX_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                default: begin
                    if (!w_frame_ok) begin
                        r_frame_err <= 1'b1;
                    end
                    r_rx_state <= RX_IDLE;
                end
            endcase
        end
    end

    // Consumes the accepted byte in RX_CHECK directly, so key_valid lands two cycles after the last edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_code_state  <= C_IDLE;
            r_key_down    <= '0;
            r_last_change <= '0;
            r_key_valid   <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            if (w_frame_ok) begin
                if (w_byte == 8'hE0) begin
                    if (r_code_state == C_IDLE) begin
                        r_code_state <= C_EXT;
                    end else if (r_code_state == C_BRK) begin
                        r_code_state <= C_EXT_BRK;
                    end
                end else if (w_byte == 8'hF0) begin
                    if (r_code_state == C_IDLE) begin
                        r_code_state <= C_BRK;
                    end else if (r_code_state == C_EXT) begin
                        r_code_state <= C_EXT_BRK;
                    end
                end else if (!w_ignored) begin
                    r_key_down[w_code] <= ~w_brk;
                    r_last_change      <= w_code;
                    r_key_valid        <= 1'b1;
                    r_code_state       <= C_IDLE;
                end
            end
        end
    end
endmodule
